// File: rtl/lsu_mem_if.sv
// Request/response bus between the M stage and the data memory.
// Signal names follow the core's existing M-stage memory port.
interface lsu_mem_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     req;
  logic                     WE;
  logic [2:0]               funct3;
  logic [ADDRESS_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0]    WD;
  logic                     ready;
  logic                     valid;
  logic [DATA_WIDTH-1:0]    RD;
  logic                     err;

  modport master (
    output req, WE, funct3, A, WD,
    input  ready, valid, RD, err
  );

  modport slave (
    input  req, WE, funct3, A, WD,
    output ready, valid, RD, err
  );
endinterface

// File: rtl/lsu_mem.sv
// Byte-addressed data memory with RV32I load/store widths, configurable wait
// states and a one-cycle valid/err response. DATA_WIDTH must be 32.
module lsu_mem #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LATENCY       = 1
) (
  input logic     clk,
  input logic     rst,
  lsu_mem_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                   state_q;
  logic [3:0]               cnt_q;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wd_q;
  logic [DATA_WIDTH-1:0]    rd_q;
  logic                     valid_q;
  logic                     err_q;

  logic [7:0] mem [2**ADDRESS_WIDTH];

  logic                     misaligned;
  logic                     illegal;
  logic                     acc_err;
  logic                     fire;
  logic [ADDRESS_WIDTH-1:0] addr_p1, addr_p2, addr_p3;
  logic [7:0]               b0, b1, b2, b3;
  logic [31:0]              ld_data;

  assign addr_p1 = addr_q + ADDRESS_WIDTH'(1);
  assign addr_p2 = addr_q + ADDRESS_WIDTH'(2);
  assign addr_p3 = addr_q + ADDRESS_WIDTH'(3);
  assign b0 = mem[addr_q];
  assign b1 = mem[addr_p1];
  assign b2 = mem[addr_p2];
  assign b3 = mem[addr_p3];

  // Last WAIT cycle: the coming edge enters RESP and performs the access.
  assign fire = (state_q == StWait) && (cnt_q == 4'd0);

  always_comb begin
    misaligned = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    if (we_q) begin
      illegal = f3_q[2] || (f3_q[1:0] == 2'b11);
    end else begin
      illegal = (f3_q[1:0] == 2'b11) || (f3_q == 3'b110);
    end
    acc_err = misaligned || illegal;
  end

  always_comb begin
    ld_data = 32'd0;
    case (f3_q)
      3'b000:  ld_data = {{24{b0[7]}}, b0};
      3'b001:  ld_data = {{16{b1[7]}}, b1, b0};
      3'b010:  ld_data = {b3, b2, b1, b0};
      3'b100:  ld_data = {24'd0, b0};
      3'b101:  ld_data = {16'd0, b1, b0};
      default: ld_data = 32'd0;
    endcase
  end

  // Storage is deliberately not reset; a reset on the RESP edge still drops the store.
  always_ff @(posedge clk) begin
    if (!rst && fire && we_q && !acc_err) begin
      mem[addr_q] <= wd_q[7:0];
      if (f3_q[1:0] != 2'b00) begin
        mem[addr_p1] <= wd_q[15:8];
      end
      if (f3_q[1:0] == 2'b10) begin
        mem[addr_p2] <= wd_q[23:16];
        mem[addr_p3] <= wd_q[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            we_q    <= bus.WE;
            f3_q    <= bus.funct3;
            addr_q  <= bus.A;
            wd_q    <= bus.WD;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StResp;
            valid_q <= 1'b1;
            err_q   <= acc_err;
            if (acc_err) begin
              rd_q <= '0;
            end else if (!we_q) begin
              rd_q <= ld_data;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready = (state_q == StIdle);
  assign bus.valid = valid_q;
  assign bus.RD    = rd_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: one instance at LATENCY=2 for the functional
// sequence, one at LATENCY=3 for reset during a pending store.
module tb_lsu_mem;

  logic clk = 1'b0;
  logic rst2, rst3;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) b2 ();
  lsu_mem_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) b3 ();

  lsu_mem #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (b2)
  );

  lsu_mem #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32), .LATENCY(3)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full access on the LATENCY=2 instance with latency and busy-window checks.
  task automatic acc2(input string tag, input logic we, input logic [2:0] f3,
                      input logic [7:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
    int e;
    int busy;
    @(negedge clk);
    chk({tag, ".ready_before"}, 32'(b2.ready), 32'd1);
    b2.req = 1'b1; b2.WE = we; b2.funct3 = f3; b2.A = a; b2.WD = wd;
    @(posedge clk); #1;
    b2.req = 1'b0; b2.WE = ~we; b2.funct3 = ~f3; b2.A = ~a; b2.WD = ~wd;
    e = 0;
    busy = 0;
    while (!b2.valid && e < 20) begin
      if (!b2.ready) busy++;
      @(posedge clk); #1;
      e++;
    end
    if (!b2.ready) busy++;
    chk({tag, ".latency"}, 32'(e), 32'd2);
    chk({tag, ".busy"}, 32'(busy), 32'd3);
    chk({tag, ".err"}, 32'(b2.err), 32'(exp_err));
    if (chk_rd) chk({tag, ".rd"}, b2.RD, exp_rd);
    @(posedge clk); #1;
    chk({tag, ".valid_after"}, {31'd0, b2.valid, 31'd0, b2.ready} == 64'd1 ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Access on the LATENCY=3 instance; returns RD and edges to valid.
  task automatic acc3(input logic we, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output int e);
    @(negedge clk);
    b3.req = 1'b1; b3.WE = we; b3.funct3 = f3; b3.A = a; b3.WD = wd;
    @(posedge clk); #1;
    b3.req = 1'b0;
    e = 0;
    while (!b3.valid && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    rd = b3.RD;
    @(posedge clk); #1;
  endtask

  initial begin
    int          pulses;
    int          e;
    logic [31:0] rd;

    rst2 = 1'b1; rst3 = 1'b1;
    b2.req = 1'b0; b2.WE = 1'b0; b2.funct3 = 3'd0; b2.A = 8'd0; b2.WD = 32'd0;
    b3.req = 1'b0; b3.WE = 1'b0; b3.funct3 = 3'd0; b3.A = 8'd0; b3.WD = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(b2.ready), 32'd1);
    chk("rst.valid", 32'(b2.valid), 32'd0);
    chk("rst.err",   32'(b2.err),   32'd0);
    chk("rst.rd",    b2.RD,         32'd0);
    rst2 = 1'b0; rst3 = 1'b0;

    // Word round trip
    acc2("sw10", 1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    acc2("lw10", 1'b0, 3'b010, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);

    // Byte lanes and extension
    acc2("sw20",  1'b1, 3'b010, 8'h20, 32'h00000000, 32'h0, 1'b0, 1'b0);
    acc2("sb21",  1'b1, 3'b000, 8'h21, 32'hFFFFFF80, 32'h0, 1'b0, 1'b0);
    acc2("lw20a", 1'b0, 3'b010, 8'h20, 32'h0, 32'h00008000, 1'b0, 1'b1);
    acc2("lb21",  1'b0, 3'b000, 8'h21, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
    acc2("lbu21", 1'b0, 3'b100, 8'h21, 32'h0, 32'h00000080, 1'b0, 1'b1);
    acc2("sh22",  1'b1, 3'b001, 8'h22, 32'hFFFF8001, 32'h0, 1'b0, 1'b0);
    acc2("lh22",  1'b0, 3'b001, 8'h22, 32'h0, 32'hFFFF8001, 1'b0, 1'b1);
    acc2("lhu22", 1'b0, 3'b101, 8'h22, 32'h0, 32'h00008001, 1'b0, 1'b1);
    acc2("lw20b", 1'b0, 3'b010, 8'h20, 32'h0, 32'h80018000, 1'b0, 1'b1);

    // Misaligned and illegal
    acc2("sw00",   1'b1, 3'b010, 8'h00, 32'h11223344, 32'h0, 1'b0, 1'b0);
    acc2("sw02mis", 1'b1, 3'b010, 8'h02, 32'h12345678, 32'h0, 1'b1, 1'b0);
    acc2("lw00",   1'b0, 3'b010, 8'h00, 32'h0, 32'h11223344, 1'b0, 1'b1);
    acc2("ld011",  1'b0, 3'b011, 8'h04, 32'h0, 32'h00000000, 1'b1, 1'b1);
    acc2("lh21mis", 1'b0, 3'b001, 8'h21, 32'h0, 32'h00000000, 1'b1, 1'b1);
    acc2("st100",  1'b1, 3'b100, 8'h30, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0);
    acc2("lb30",   1'b0, 3'b000, 8'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b1);

    // Busy: second request held during WAIT is ignored
    @(negedge clk);
    b2.req = 1'b1; b2.WE = 1'b0; b2.funct3 = 3'b010; b2.A = 8'h10;
    @(posedge clk); #1;
    b2.A = 8'h20;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (b2.valid) pulses++;
    end
    chk("busy.rd", b2.RD, 32'hDEADBEEF);
    b2.req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (b2.valid) pulses++;
    end
    chk("busy.pulses", 32'(pulses), 32'd1);
    acc2("busy.next", 1'b0, 3'b010, 8'h20, 32'h0, 32'h80018000, 1'b0, 1'b1);

    // Reset mid-operation on the LATENCY=3 instance
    acc3(1'b1, 3'b010, 8'h40, 32'h01020304, rd, e);
    chk("l3.sw.latency", 32'(e), 32'd3);
    @(negedge clk);
    b3.req = 1'b1; b3.WE = 1'b1; b3.funct3 = 3'b010; b3.A = 8'h40; b3.WD = 32'hAAAA5555;
    @(posedge clk); #1;
    b3.req = 1'b0;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    chk("l3.rst.ready", 32'(b3.ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (b3.valid) pulses++;
      @(posedge clk); #1;
    end
    chk("l3.rst.pulses", 32'(pulses), 32'd0);
    acc3(1'b0, 3'b010, 8'h40, 32'h0, rd, e);
    chk("l3.lw.latency", 32'(e), 32'd3);
    chk("l3.lw.rd", rd, 32'h01020304);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
